// File: rtl/leve_ifetch_lbuf_if.sv
// leve_ifetch_lbuf_if: fetch-side bundle for the instruction line buffer.
//   PC request      : PC_VALID, PC, PC_READY
//   instruction out : INST_VALID, INST_PAYLOAD, INST_PC, INST_READY
//   AXI read (AR/R) : ARVALID, ARREADY, ARADDR, ARBURST, ARLEN,
//                     RVALID, RREADY, RDATA, RLAST
// Modports:
//   master - the line buffer (drives PC_READY, the instruction slot and the AXI
//            read master signals)
//   slave  - the surrounding pipeline/interconnect
// XLEN and ADDR_W must match the parameters of the attached leve_ifetch_lbuf.
interface leve_ifetch_lbuf_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              PC_VALID;
  logic [XLEN-1:0]   PC;
  logic              PC_READY;

  logic              INST_VALID;
  logic [31:0]       INST_PAYLOAD;
  logic [XLEN-1:0]   INST_PC;
  logic              INST_READY;

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [1:0]        ARBURST;
  logic [7:0]        ARLEN;

  logic              RVALID;
  logic              RREADY;
  logic [31:0]       RDATA;
  logic              RLAST;

  modport master (
    input  PC_VALID, PC, INST_READY, ARREADY, RVALID, RDATA, RLAST,
    output PC_READY, INST_VALID, INST_PAYLOAD, INST_PC,
           ARVALID, ARADDR, ARBURST, ARLEN, RREADY
  );

  modport slave (
    output PC_VALID, PC, INST_READY, ARREADY, RVALID, RDATA, RLAST,
    input  PC_READY, INST_VALID, INST_PAYLOAD, INST_PC,
           ARVALID, ARADDR, ARBURST, ARLEN, RREADY
  );
endinterface

// File: rtl/leve_ifetch_lbuf.sv
// leve_ifetch_lbuf: single-line instruction fetch buffer between the PC stage
// and decode. A miss launches an aligned AXI INCR burst of LINE_WORDS beats;
// each 32-bit word becomes hittable the cycle after its beat is written, so
// fetch streams behind the fill. Results leave through a registered
// VALID/READY slot with one cycle of hit latency.
// Ports:
//   CLK, RSTn - clock, asynchronous active-low reset
//   bus       - leve_ifetch_lbuf_if.master (PC request, instruction out, AXI read)
//   HIT_CNT, MISS_CNT - saturating statistics, only with LEVE_IFETCH_LBUF_STATS_EN
// Optional feature macro: LEVE_IFETCH_LBUF_STATS_EN.
module leve_ifetch_lbuf #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  leve_ifetch_lbuf_if.master bus
`ifdef LEVE_IFETCH_LBUF_STATS_EN
  ,
  output logic [31:0]        HIT_CNT,
  output logic [31:0]        MISS_CNT
`endif
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam int unsigned OffW = IdxW + 2;
  localparam int unsigned TagW = XLEN - OffW;

  typedef enum logic [1:0] {StIdle, StAr, StRd, StDrain} state_e;

  state_e                st_q;
  logic [TagW-1:0]       tag_q;       // line tag, also the tag being filled
  logic [TagW-1:0]       pend_tag_q;
  logic                  pend_q;
  logic                  line_valid_q;
  logic [LINE_WORDS-1:0] wvalid_q;
  logic [IdxW-1:0]       beat_q;
  logic [31:0]           data_q [LINE_WORDS];
  logic                  arvalid_q;
  logic                  rready_q;
  logic [ADDR_W-1:0]     araddr_q;
  logic                  inst_valid_q;
  logic [31:0]           inst_payload_q;
  logic [XLEN-1:0]       inst_pc_q;

  logic [IdxW-1:0] pc_idx;
  logic [TagW-1:0] pc_tag;
  logic            unused_pc;
  logic            hit, slot_free, pc_ready;
  logic            tag_diff, beat, last_beat;
  logic [TagW-1:0] next_pend_tag;
  logic            start_fill, go_drain, go_idle, wr_beat;
  logic [TagW-1:0] fill_tag;

  assign pc_idx    = bus.PC[OffW-1:2];
  assign pc_tag    = bus.PC[XLEN-1:OffW];
  assign unused_pc = ^bus.PC[1:0];

  assign hit       = line_valid_q && (pc_tag == tag_q) && wvalid_q[pc_idx];
  assign slot_free = !inst_valid_q || bus.INST_READY;
  assign pc_ready  = bus.PC_VALID && hit && slot_free;

  // A request to another line while a fill is in flight.
  assign tag_diff      = bus.PC_VALID && (pc_tag != tag_q);
  assign next_pend_tag = tag_diff ? pc_tag : pend_tag_q;
  assign beat          = bus.RVALID && rready_q;
  assign last_beat     = beat && bus.RLAST;
  assign wr_beat       = (st_q == StRd) && beat && !tag_diff;

  // Transition decode; the state register itself lives in the FSM block.
  always_comb begin
    start_fill = 1'b0;
    go_drain   = 1'b0;
    go_idle    = 1'b0;
    fill_tag   = pc_tag;
    unique case (st_q)
      StIdle: begin
        // Covers both a tag miss and a word hole left by an early RLAST.
        if (bus.PC_VALID && !hit) start_fill = 1'b1;
      end
      StRd: begin
        if (tag_diff) begin
          if (last_beat) start_fill = 1'b1;
          else           go_drain   = 1'b1;
        end else if (last_beat) begin
          if (pend_q) begin
            start_fill = 1'b1;
            fill_tag   = pend_tag_q;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      StDrain: begin
        if (last_beat) begin
          start_fill = 1'b1;
          fill_tag   = next_pend_tag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q         <= StIdle;
      tag_q        <= '0;
      pend_tag_q   <= '0;
      pend_q       <= 1'b0;
      line_valid_q <= 1'b0;
      wvalid_q     <= '0;
      beat_q       <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
    end else if (start_fill) begin
      st_q         <= StAr;
      tag_q        <= fill_tag;
      pend_q       <= 1'b0;
      line_valid_q <= 1'b1;
      wvalid_q     <= '0;
      beat_q       <= '0;
      arvalid_q    <= 1'b1;
      rready_q     <= 1'b0;
      araddr_q     <= ADDR_W'({fill_tag, {OffW{1'b0}}});
    end else begin
      unique case (st_q)
        StAr: begin
          // ARVALID stays up until accepted; a redirect only queues.
          if (tag_diff) begin
            pend_q     <= 1'b1;
            pend_tag_q <= pc_tag;
          end
          if (bus.ARREADY) begin
            st_q      <= StRd;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        StRd: begin
          if (go_drain) begin
            st_q         <= StDrain;
            line_valid_q <= 1'b0;
            pend_q       <= 1'b1;
            pend_tag_q   <= pc_tag;
          end else begin
            if (wr_beat) begin
              wvalid_q[beat_q] <= 1'b1;
              beat_q           <= beat_q + 1'b1;
            end
            if (go_idle) begin
              st_q     <= StIdle;
              rready_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (tag_diff) pend_tag_q <= pc_tag;
        end
        default: ;
      endcase
    end
  end

  // Line data needs no reset: word-valid bits gate every read.
  always_ff @(posedge CLK) begin
    if (wr_beat) data_q[beat_q] <= bus.RDATA;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      inst_valid_q   <= 1'b0;
      inst_payload_q <= '0;
      inst_pc_q      <= '0;
    end else if (pc_ready) begin
      inst_valid_q   <= 1'b1;
      inst_payload_q <= data_q[pc_idx];
      inst_pc_q      <= bus.PC;
    end else if (bus.INST_READY) begin
      inst_valid_q <= 1'b0;
    end
  end

`ifdef LEVE_IFETCH_LBUF_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        miss_evt;

  assign miss_evt = ((st_q == StIdle) && start_fill) || go_drain;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (pc_ready && (hit_cnt_q != 32'hFFFF_FFFF))  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif

  assign bus.PC_READY     = pc_ready;
  assign bus.INST_VALID   = inst_valid_q;
  assign bus.INST_PAYLOAD = inst_payload_q;
  assign bus.INST_PC      = inst_pc_q;
  assign bus.ARVALID      = arvalid_q;
  assign bus.ARADDR       = araddr_q;
  assign bus.ARBURST      = 2'b01;
  assign bus.ARLEN        = 8'(LINE_WORDS - 1);
  assign bus.RREADY       = rready_q;

endmodule
